vc_access_ctrl: RTL and testbench
=================================

VC_ACCESS_CTRL -- requirements
Module: vc_access_ctrl

Interface
REQ-001 SHALL have the following ports, clock and reset first (name, direction, width, meaning); reset is synchronous and active-high:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_val_i / req_rdy_o  in/out  1/1  lookup request handshake
- req_rw_i  in  1  L15_DTAG_RW_READ or L15_DTAG_RW_WRITE
- req_addr_i  in  VC_ADDR_WIDTH  line address
- req_wmask_i, req_wdata_i  in  L15_CACHELINE_WIDTH  byte-lane mask and data for writes
- resp_val_o / resp_rdy_i  out/in  1/1  response handshake
- resp_hit_o  out  1  line present with MESI != I
- resp_mesi_o  out  L15_MESI_STATE_WIDTH  MESI state after the access
- resp_data_o  out  L15_CACHELINE_WIDTH  read data; 0 on miss or write
- evict_val_i / evict_rdy_o  in/out  1/1  L1.5 eviction handshake
- evict_addr_i, evict_data_i  in  VC_ADDR_WIDTH / L15_CACHELINE_WIDTH  evicted line
- check_val_o, check_rw_o, check_addr_o  out  1/1/VC_ADDR_WIDTH  S1 lookup to the victim cache
- match_index_i, match_mesi_i  in  VC_NUM_ENTRIES_LOG2 / L15_MESI_STATE_WIDTH  registered S1 result, valid the cycle after check_val_o
- fetch_val_o, fetch_rw_o, fetch_index_o  out  1/1/VC_NUM_ENTRIES_LOG2  S2 access
- write_mask_o, write_data_o  out  L15_CACHELINE_WIDTH  S2 write operands
- mesi_write_val_o, mesi_write_state_o  out  1 / L15_MESI_STATE_WIDTH  S2 MESI update
- fetch_data_i  in  L15_CACHELINE_WIDTH  registered S2 read data, valid the cycle after fetch_val_o
- store_evict_val_o, store_evict_addr_o, store_evict_data_o  out  1/VC_ADDR_WIDTH/L15_CACHELINE_WIDTH  S3 insert
- hit_cnt_o, miss_cnt_o  out  16/16  saturating statistics

Function
REQ-002 SHALL implement FSM IDLE -> CHECK -> MATCH -> (DATA) -> RESP -> IDLE, one request in flight.
REQ-003 req_rdy_o SHALL be 1 only in IDLE with the eviction FIFO empty; accepting latches rw, addr, mask, data.
REQ-004 CHECK: check_val_o=1, check_rw_o=L15_DTAG_RW_READ for both reads and writes, check_addr_o=latched addr; all check_* outputs 0 otherwise.
REQ-005 MATCH: hit when match_mesi_i != L15_MESI_STATE_I; on hit drive fetch_val_o=1, fetch_index_o=match_index_i, fetch_rw_o=latched rw.
REQ-006 Write hit in MATCH: write_mask_o/write_data_o=latched mask/data, mesi_write_val_o=1, mesi_write_state_o=L15_MESI_STATE_M; next RESP with resp_mesi_o=M.
REQ-007 Read hit in MATCH: next DATA, which captures fetch_data_i, then RESP with resp_mesi_o=match_mesi_i.
REQ-008 Miss in MATCH: no fetch or MESI write; next RESP with resp_hit_o=0, resp_mesi_o=I, resp_data_o=0.
REQ-009 Latency from acceptance edge T: resp_val_o high from T+4 on a read hit and from T+3 otherwise.
REQ-010 RESP SHALL hold resp_* stable until resp_val_o & resp_rdy_i, then return to IDLE.
REQ-011 Evictions SHALL enter a 2-entry FIFO; evict_rdy_o = FIFO not full; a simultaneous push and pop on a full FIFO is not permitted.
REQ-012 store_evict_val_o SHALL pop one entry per cycle only in IDLE or RESP, never in CHECK, MATCH or DATA.
REQ-013 hit_cnt_o / miss_cnt_o SHALL increment once per request in MATCH and saturate at 16'hFFFF.

Reset
REQ-014 While rst=1, next state SHALL be IDLE; FIFO empty; counters 0; resp and latched registers 0.
REQ-015 Every output SHALL be 0 during reset and the first cycle after it, except req_rdy_o=1 and evict_rdy_o=1; reset mid-request drops that request with no response.

Structure
REQ-016 VC_ADDR_WIDTH, VC_NUM_ENTRIES_LOG2, L15_CACHELINE_WIDTH, L15_MESI_STATE_* and L15_DTAG_RW_* SHALL come from the shared l15 define header; the FSM encoding is local.
REQ-017 The eviction FIFO SHALL be a sub-module named vc_evict_fifo.

Verification
REQ-018 Evict addr 0x10 data A, then read 0x10 -> resp_hit=1, mesi=E, data=A at T+4.
REQ-019 Write 0x10 mask low 64 bits = 1s, data B, then read 0x10 -> mesi=M, data={A[127:64],B[63:0]}.
REQ-020 Read 0x99 on an empty cache -> resp_hit=0, mesi=I, data=0 at T+3; miss_cnt=1.
REQ-021 Two back-to-back evictions while a request is in MATCH -> evict_rdy_o=0 on the third; inserts occur only in RESP/IDLE; req_rdy_o=0 until the FIFO is empty.
REQ-022 resp_rdy_i=0 for 5 cycles -> resp_* stable and req_rdy_o=0; assert rst during CHECK -> no response, all outputs per REQ-015.

Source files
------------

// File: rtl/vc_access_ctrl_pkg.sv
// rtl/vc_access_ctrl_pkg.sv - shared l15/victim-cache widths, encodings and helpers
package vc_access_ctrl_pkg;
  localparam int VC_ADDR_WIDTH        = 40;
  localparam int VC_NUM_ENTRIES_LOG2  = 4;
  localparam int L15_CACHELINE_WIDTH  = 128;
  localparam int L15_MESI_STATE_WIDTH = 2;

  localparam logic [L15_MESI_STATE_WIDTH-1:0] L15_MESI_STATE_I = 2'b00;
  localparam logic [L15_MESI_STATE_WIDTH-1:0] L15_MESI_STATE_S = 2'b01;
  localparam logic [L15_MESI_STATE_WIDTH-1:0] L15_MESI_STATE_E = 2'b10;
  localparam logic [L15_MESI_STATE_WIDTH-1:0] L15_MESI_STATE_M = 2'b11;

  localparam logic L15_DTAG_RW_READ  = 1'b0;
  localparam logic L15_DTAG_RW_WRITE = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/vc_evict_fifo.sv
// rtl/vc_evict_fifo.sv - two-entry FIFO buffering L1.5 evictions before victim-cache insert
module vc_evict_fifo
  import vc_access_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_val,
  output logic                           push_rdy,
  input  logic [VC_ADDR_WIDTH-1:0]       push_addr,
  input  logic [L15_CACHELINE_WIDTH-1:0] push_data,
  input  logic                           pop_en,
  output logic                           pop_val,
  output logic [VC_ADDR_WIDTH-1:0]       pop_addr,
  output logic [L15_CACHELINE_WIDTH-1:0] pop_data
);
  logic [VC_ADDR_WIDTH-1:0]       addr_mem [2];
  logic [L15_CACHELINE_WIDTH-1:0] data_mem [2];
  logic                           wr_ptr;
  logic                           rd_ptr;
  logic [1:0]                     count;
  logic                           push;
  logic                           pop;

  // Push is refused when full, so a push+pop on a full FIFO cannot occur.
  assign push_rdy = (count != 2'd2);
  assign pop_val  = (count != 2'd0);
  assign push     = push_val && push_rdy;
  assign pop      = pop_en && pop_val;
  assign pop_addr = addr_mem[rd_ptr];
  assign pop_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/vc_access_ctrl.sv
// rtl/vc_access_ctrl.sv - victim-cache access sequencer: lookup, data/MESI access, eviction insert
module vc_access_ctrl
  import vc_access_ctrl_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_val_i,
  output logic                            req_rdy_o,
  input  logic                            req_rw_i,
  input  logic [VC_ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [L15_CACHELINE_WIDTH-1:0]  req_wmask_i,
  input  logic [L15_CACHELINE_WIDTH-1:0]  req_wdata_i,
  output logic                            resp_val_o,
  input  logic                            resp_rdy_i,
  output logic                            resp_hit_o,
  output logic [L15_MESI_STATE_WIDTH-1:0] resp_mesi_o,
  output logic [L15_CACHELINE_WIDTH-1:0]  resp_data_o,
  input  logic                            evict_val_i,
  output logic                            evict_rdy_o,
  input  logic [VC_ADDR_WIDTH-1:0]        evict_addr_i,
  input  logic [L15_CACHELINE_WIDTH-1:0]  evict_data_i,
  output logic                            check_val_o,
  output logic                            check_rw_o,
  output logic [VC_ADDR_WIDTH-1:0]        check_addr_o,
  input  logic [VC_NUM_ENTRIES_LOG2-1:0]  match_index_i,
  input  logic [L15_MESI_STATE_WIDTH-1:0] match_mesi_i,
  output logic                            fetch_val_o,
  output logic                            fetch_rw_o,
  output logic [VC_NUM_ENTRIES_LOG2-1:0]  fetch_index_o,
  output logic [L15_CACHELINE_WIDTH-1:0]  write_mask_o,
  output logic [L15_CACHELINE_WIDTH-1:0]  write_data_o,
  output logic                            mesi_write_val_o,
  output logic [L15_MESI_STATE_WIDTH-1:0] mesi_write_state_o,
  input  logic [L15_CACHELINE_WIDTH-1:0]  fetch_data_i,
  output logic                            store_evict_val_o,
  output logic [VC_ADDR_WIDTH-1:0]        store_evict_addr_o,
  output logic [L15_CACHELINE_WIDTH-1:0]  store_evict_data_o,
  output logic [15:0]                     hit_cnt_o,
  output logic [15:0]                     miss_cnt_o
);
  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_MATCH, ST_DATA, ST_RESP} state_e;

  state_e                          state, state_nxt;
  logic                            rw_q;
  logic [VC_ADDR_WIDTH-1:0]        addr_q;
  logic [L15_CACHELINE_WIDTH-1:0]  mask_q, wdata_q;
  logic                            resp_hit_q;
  logic [L15_MESI_STATE_WIDTH-1:0] resp_mesi_q;
  logic [L15_CACHELINE_WIDTH-1:0]  resp_data_q;
  logic [15:0]                     hit_cnt_q, miss_cnt_q;

  logic                            fifo_val, fifo_push_rdy, pop_allowed;
  logic [VC_ADDR_WIDTH-1:0]        fifo_addr;
  logic [L15_CACHELINE_WIDTH-1:0]  fifo_data;
  logic                            match_hit, accept;

  assign match_hit   = (match_mesi_i != L15_MESI_STATE_I);
  assign accept      = (state == ST_IDLE) && !fifo_val && req_val_i;
  // Inserts would race with an in-flight lookup, so they are held off outside IDLE/RESP.
  assign pop_allowed = !rst && ((state == ST_IDLE) || (state == ST_RESP));

  vc_evict_fifo u_evict_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_val  (evict_val_i),
    .push_rdy  (fifo_push_rdy),
    .push_addr (evict_addr_i),
    .push_data (evict_data_i),
    .pop_en    (pop_allowed),
    .pop_val   (fifo_val),
    .pop_addr  (fifo_addr),
    .pop_data  (fifo_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    req_rdy_o          = 1'b0;
    resp_val_o         = 1'b0;
    check_val_o        = 1'b0;
    check_rw_o         = L15_DTAG_RW_READ;
    check_addr_o       = '0;
    fetch_val_o        = 1'b0;
    fetch_rw_o         = L15_DTAG_RW_READ;
    fetch_index_o      = '0;
    write_mask_o       = '0;
    write_data_o       = '0;
    mesi_write_val_o   = 1'b0;
    mesi_write_state_o = L15_MESI_STATE_I;
    if (rst) begin
      req_rdy_o = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          req_rdy_o = !fifo_val;
          if (accept) state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          check_val_o  = 1'b1;
          check_addr_o = addr_q;
          state_nxt    = ST_MATCH;
        end
        ST_MATCH: begin
          state_nxt = ST_RESP;
          if (match_hit) begin
            fetch_val_o   = 1'b1;
            fetch_rw_o    = rw_q;
            fetch_index_o = match_index_i;
            if (rw_q == L15_DTAG_RW_WRITE) begin
              write_mask_o       = mask_q;
              write_data_o       = wdata_q;
              mesi_write_val_o   = 1'b1;
              mesi_write_state_o = L15_MESI_STATE_M;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: state_nxt = ST_RESP;
        ST_RESP: begin
          resp_val_o = 1'b1;
          if (resp_rdy_i) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q        <= L15_DTAG_RW_READ;
      addr_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      resp_hit_q  <= 1'b0;
      resp_mesi_q <= L15_MESI_STATE_I;
      resp_data_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (accept) begin
        rw_q    <= req_rw_i;
        addr_q  <= req_addr_i;
        mask_q  <= req_wmask_i;
        wdata_q <= req_wdata_i;
      end
      if (state == ST_MATCH) begin
        resp_hit_q  <= match_hit;
        resp_data_q <= '0;
        if (match_hit) begin
          resp_mesi_q <= (rw_q == L15_DTAG_RW_WRITE) ? L15_MESI_STATE_M : match_mesi_i;
          hit_cnt_q   <= sat_inc16(hit_cnt_q);
        end else begin
          resp_mesi_q <= L15_MESI_STATE_I;
          miss_cnt_q  <= sat_inc16(miss_cnt_q);
        end
      end
      if (state == ST_DATA) resp_data_q <= fetch_data_i;
    end
  end

  assign resp_hit_o         = resp_val_o && resp_hit_q;
  assign resp_mesi_o        = resp_val_o ? resp_mesi_q : L15_MESI_STATE_I;
  assign resp_data_o        = resp_val_o ? resp_data_q : '0;
  assign evict_rdy_o        = rst || fifo_push_rdy;
  assign store_evict_val_o  = pop_allowed && fifo_val;
  assign store_evict_addr_o = store_evict_val_o ? fifo_addr : '0;
  assign store_evict_data_o = store_evict_val_o ? fifo_data : '0;
  assign hit_cnt_o          = rst ? 16'd0 : hit_cnt_q;
  assign miss_cnt_o         = rst ? 16'd0 : miss_cnt_q;
endmodule

// File: tb/tb_vc_access_ctrl.sv
// tb/tb_vc_access_ctrl.sv - randomized bench with victim-cache emulator and transaction-level reference model
module tb_vc_access_ctrl;
  import vc_access_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_val = 1'b0, req_rw = 1'b0;
  logic [39:0]  req_addr = '0;
  logic [127:0] req_wmask = '0, req_wdata = '0;
  logic         resp_rdy = 1'b1;
  logic         evict_val = 1'b0;
  logic [39:0]  evict_addr = '0;
  logic [127:0] evict_data = '0;
  logic [3:0]   match_index = '0;
  logic [1:0]   match_mesi = '0;
  logic [127:0] fetch_data = '0;

  logic         req_rdy_o, resp_val_o, resp_hit_o, evict_rdy_o, check_val_o, check_rw_o;
  logic [1:0]   resp_mesi_o, mesi_write_state_o;
  logic [127:0] resp_data_o, write_mask_o, write_data_o, store_evict_data_o;
  logic [39:0]  check_addr_o, store_evict_addr_o;
  logic         fetch_val_o, fetch_rw_o, mesi_write_val_o, store_evict_val_o;
  logic [3:0]   fetch_index_o;
  logic [15:0]  hit_cnt_o, miss_cnt_o;

  vc_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_val_i(req_val), .req_rdy_o(req_rdy_o), .req_rw_i(req_rw), .req_addr_i(req_addr),
    .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
    .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy), .resp_hit_o(resp_hit_o),
    .resp_mesi_o(resp_mesi_o), .resp_data_o(resp_data_o),
    .evict_val_i(evict_val), .evict_rdy_o(evict_rdy_o), .evict_addr_i(evict_addr), .evict_data_i(evict_data),
    .check_val_o(check_val_o), .check_rw_o(check_rw_o), .check_addr_o(check_addr_o),
    .match_index_i(match_index), .match_mesi_i(match_mesi),
    .fetch_val_o(fetch_val_o), .fetch_rw_o(fetch_rw_o), .fetch_index_o(fetch_index_o),
    .write_mask_o(write_mask_o), .write_data_o(write_data_o),
    .mesi_write_val_o(mesi_write_val_o), .mesi_write_state_o(mesi_write_state_o),
    .fetch_data_i(fetch_data),
    .store_evict_val_o(store_evict_val_o), .store_evict_addr_o(store_evict_addr_o),
    .store_evict_data_o(store_evict_data_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Victim-cache array emulator (the block on the other side of check/fetch/store).
  logic [39:0]  e_addr [16];
  logic [1:0]   e_mesi [16];
  logic [127:0] e_data [16];
  int           e_next = 0;

  // Reference model: what the cache holds, what is queued, what is in flight.
  logic [1:0]   r_mesi [logic [39:0]];
  logic [127:0] r_data [logic [39:0]];
  logic [39:0]  q_addr [$];
  logic [127:0] q_data [$];
  bit           busy = 0;
  int           k = 0, lat = 0, hit_n = 0, miss_n = 0;
  bit           m_rw, m_hit;
  logic [39:0]  m_addr;
  logic [127:0] m_mask, m_wdata, m_data;
  logic [1:0]   m_mesi;

  bit           s_acc, s_resp_val, s_resp_hit, s_req_rdy, s_evict_rdy, s_sev;
  logic [1:0]   s_resp_mesi;
  logic [127:0] s_resp_data;
  logic [15:0]  s_hit_cnt, s_miss_cnt;
  int           r_lat;
  bit           r_hit;
  logic [1:0]   r_mesi_o;
  logic [127:0] r_data_o;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int e_find(input logic [39:0] a);
    for (int i = 0; i < 16; i++)
      if (e_mesi[i] != L15_MESI_STATE_I && e_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    bit rp, ep, acc, push, efetch;
    int fi;
    logic [3:0]   n_idx;
    logic [1:0]   n_mesi;
    logic [127:0] n_fetch;
    @(negedge clk);
    cyc++;
    s_resp_val = resp_val_o; s_resp_hit = resp_hit_o; s_resp_mesi = resp_mesi_o;
    s_resp_data = resp_data_o; s_req_rdy = req_rdy_o; s_evict_rdy = evict_rdy_o;
    s_sev = store_evict_val_o; s_hit_cnt = hit_cnt_o; s_miss_cnt = miss_cnt_o;
    rp = busy && k >= lat;
    ep = q_addr.size() > 0 && (!busy || rp);
    acc = 0;
    if (rst) begin
      chk("rst_rdys", {req_rdy_o, evict_rdy_o}, 2'b11);
      chk("rst_ctl", {resp_val_o, resp_hit_o, resp_mesi_o, check_val_o, check_rw_o, fetch_val_o,
                      fetch_rw_o, fetch_index_o, mesi_write_val_o, mesi_write_state_o, store_evict_val_o}, 0);
      chk("rst_wide", resp_data_o | write_mask_o | write_data_o | store_evict_data_o, 0);
      chk("rst_misc", {check_addr_o, store_evict_addr_o, hit_cnt_o, miss_cnt_o}, 0);
    end else begin
      chk("req_rdy", req_rdy_o, !busy && q_addr.size() == 0);
      chk("evict_rdy", evict_rdy_o, q_addr.size() < 2);
      chk("resp_val", resp_val_o, rp);
      if (rp) begin
        chk("resp_hit", resp_hit_o, m_hit);
        chk("resp_mesi", resp_mesi_o, m_mesi);
        chk("resp_data", resp_data_o, m_data);
      end else begin
        chk("resp_idle", {125'b0, resp_hit_o, resp_mesi_o} | resp_data_o, 0);
      end
      chk("check_val", check_val_o, busy && k == 1);
      if (busy && k == 1) chk("check_addr_rw", {check_rw_o, check_addr_o}, {1'b0, m_addr});
      efetch = busy && k == 2 && m_hit;
      chk("fetch_val", fetch_val_o, efetch);
      if (efetch) chk("fetch_rw_idx", {fetch_rw_o, fetch_index_o}, {m_rw, 4'(e_find(m_addr))});
      chk("mesi_write_val", mesi_write_val_o, efetch && m_rw);
      if (efetch && m_rw) begin
        chk("mesi_write_state", mesi_write_state_o, L15_MESI_STATE_M);
        chk("write_mask", write_mask_o, m_mask);
        chk("write_data", write_data_o, m_wdata);
      end
      chk("store_evict_val", store_evict_val_o, ep);
      if (ep) begin
        chk("store_evict_addr", store_evict_addr_o, q_addr[0]);
        chk("store_evict_data", store_evict_data_o, q_data[0]);
      end
      if (!busy || k >= 3) chk("counters", {hit_cnt_o, miss_cnt_o}, {16'(hit_n), 16'(miss_n)});
    end

    // Emulator responses, registered: visible the cycle after the request.
    n_idx = 4'($urandom_range(0, 15));
    n_mesi = L15_MESI_STATE_I;
    n_fetch = rnd128();
    if (check_val_o) begin
      fi = e_find(check_addr_o);
      if (fi >= 0) begin n_idx = 4'(fi); n_mesi = e_mesi[fi]; end
    end
    if (fetch_val_o && fetch_rw_o == L15_DTAG_RW_READ) n_fetch = e_data[fetch_index_o];
    if (fetch_val_o && fetch_rw_o == L15_DTAG_RW_WRITE)
      e_data[fetch_index_o] = (e_data[fetch_index_o] & ~write_mask_o) | (write_data_o & write_mask_o);
    if (mesi_write_val_o) e_mesi[fetch_index_o] = mesi_write_state_o;
    if (store_evict_val_o) begin
      fi = e_find(store_evict_addr_o);
      if (fi < 0) begin fi = e_next; e_next = (e_next + 1) % 16; end
      e_addr[fi] = store_evict_addr_o; e_data[fi] = store_evict_data_o; e_mesi[fi] = L15_MESI_STATE_E;
    end

    if (rst) begin
      busy = 0; hit_n = 0; miss_n = 0;
      q_addr.delete(); q_data.delete();
    end else begin
      acc  = !busy && q_addr.size() == 0 && req_val;
      push = evict_val && q_addr.size() < 2;
      if (ep) begin
        r_mesi[q_addr[0]] = L15_MESI_STATE_E;
        r_data[q_addr[0]] = q_data[0];
        void'(q_addr.pop_front()); void'(q_data.pop_front());
      end
      if (push) begin q_addr.push_back(evict_addr); q_data.push_back(evict_data); end
      if (acc) begin
        m_rw = req_rw; m_addr = req_addr; m_mask = req_wmask; m_wdata = req_wdata;
        m_hit = r_mesi.exists(req_addr) && r_mesi[req_addr] != L15_MESI_STATE_I;
        m_data = '0; lat = 3;
        if (!m_hit) begin
          m_mesi = L15_MESI_STATE_I;
          if (miss_n < 65535) miss_n++;
        end else begin
          if (hit_n < 65535) hit_n++;
          if (m_rw) begin
            m_mesi = L15_MESI_STATE_M;
            r_data[req_addr] = (r_data[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            r_mesi[req_addr] = L15_MESI_STATE_M;
          end else begin
            m_mesi = r_mesi[req_addr]; m_data = r_data[req_addr]; lat = 4;
          end
        end
        busy = 1; k = 1;
      end else if (busy) begin
        if (rp && resp_rdy) busy = 0;
        else k++;
      end
    end
    s_acc = acc;
    @(posedge clk);
    #1;
    match_index = n_idx; match_mesi = n_mesi; fetch_data = n_fetch;
  endtask

  task automatic do_req(input bit rw, input logic [39:0] a, input logic [127:0] mk,
                        input logic [127:0] d, input int hold);
    int n;
    bit got;
    logic [127:0] first_data;
    req_rw = rw; req_addr = a; req_wmask = mk; req_wdata = d; req_val = 1'b1;
    resp_rdy = (hold == 0);
    n = 0;
    do begin tick(); n++; end while (!s_acc && n < 20);
    req_val = 1'b0;
    if (!s_acc) begin chk("accept_timeout", 0, 1); resp_rdy = 1'b1; return; end
    n = 0; got = 0;
    while (!got && n < 20) begin tick(); n++; got = s_resp_val; end
    if (!got) begin chk("resp_timeout", 0, 1); resp_rdy = 1'b1; return; end
    r_lat = n; r_hit = s_resp_hit; r_mesi_o = s_resp_mesi; r_data_o = s_resp_data;
    if (hold > 0) begin
      first_data = s_resp_data;
      repeat (hold - 1) tick();
      chk("hold_stable", {s_resp_val, s_resp_hit, s_resp_mesi, s_resp_data[63:0]},
          {1'b1, r_hit, r_mesi_o, first_data[63:0]});
      chk("hold_req_rdy", s_req_rdy, 0);
      resp_rdy = 1'b1;
      tick();
    end
  endtask

  localparam logic [127:0] A = 128'h0123_4567_89ab_cdef_1122_3344_5566_7788;
  localparam logic [127:0] B = 128'hfedc_ba98_7654_3210_aabb_ccdd_eeff_0099;
  localparam logic [127:0] C = 128'h5a5a_0000_ffff_1234_dead_beef_cafe_f00d;

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) begin e_addr[i] = '0; e_mesi[i] = L15_MESI_STATE_I; e_data[i] = '0; end
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rdys", {s_req_rdy, s_evict_rdy}, 2'b11);
    chk("post_rst_cnt", {s_hit_cnt, s_miss_cnt}, 0);

    evict_val = 1'b1; evict_addr = 40'h10; evict_data = A;
    tick();
    evict_val = 1'b0;
    tick(); tick();
    do_req(L15_DTAG_RW_READ, 40'h10, '0, '0, 0);
    chk("r18_lat", r_lat, 4);
    chk("r18_resp", {r_hit, r_mesi_o}, 3'b110);
    chk("r18_data", r_data_o, A);

    do_req(L15_DTAG_RW_WRITE, 40'h10, {64'h0, {64{1'b1}}}, B, 0);
    chk("r19_wr_lat", r_lat, 3);
    chk("r19_wr_resp", {r_hit, r_mesi_o, r_data_o}, {1'b1, 2'b11, 128'h0});
    do_req(L15_DTAG_RW_READ, 40'h10, '0, '0, 0);
    chk("r19_mesi", r_mesi_o, 2'b11);
    chk("r19_data", r_data_o, {A[127:64], B[63:0]});

    do_req(L15_DTAG_RW_READ, 40'h99, '0, '0, 0);
    chk("r20_lat", r_lat, 3);
    chk("r20_resp", {r_hit, r_mesi_o, r_data_o}, 0);
    chk("r20_cnts", {s_hit_cnt, s_miss_cnt}, {16'd3, 16'd1});

    req_rw = L15_DTAG_RW_READ; req_addr = 40'h10; req_val = 1'b1; resp_rdy = 1'b1;
    tick();
    req_val = 1'b0;
    tick();
    evict_val = 1'b1; evict_addr = 40'h20; evict_data = C;
    tick();
    evict_addr = 40'h30; evict_data = B;
    tick();
    evict_addr = 40'h40;
    tick();
    chk("r21_full", s_evict_rdy, 0);
    chk("r21_insert_in_resp", {s_resp_val, s_sev}, 2'b11);
    evict_val = 1'b0;
    tick();
    chk("r21_req_blocked", {s_req_rdy, s_sev}, 2'b01);
    tick(); tick();

    do_req(L15_DTAG_RW_READ, 40'h20, '0, '0, 5);
    chk("r22_resp", {r_hit, r_mesi_o}, 3'b110);
    chk("r22_data", r_data_o, C);

    req_rw = L15_DTAG_RW_READ; req_addr = 40'h30; req_val = 1'b1;
    tick();
    req_val = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    repeat (6) begin tick(); if (s_resp_val) seen++; end
    chk("rst_no_resp", seen, 0);
    chk("rst_cnt_clear", {s_hit_cnt, s_miss_cnt}, 0);

    repeat (2500) begin
      rst        = ($urandom_range(0, 499) == 0);
      req_val    = $urandom_range(0, 1);
      req_rw     = $urandom_range(0, 1);
      req_addr   = 40'h100 + 40'($urandom_range(0, 9));
      req_wmask  = ($urandom_range(0, 3) == 0) ? {128{1'b1}} : rnd128();
      req_wdata  = rnd128();
      evict_val  = ($urandom_range(0, 3) == 0);
      evict_addr = 40'h100 + 40'($urandom_range(0, 7));
      evict_data = rnd128();
      resp_rdy   = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; req_val = 1'b0; evict_val = 1'b0; resp_rdy = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
